// File: rtl/sync_dp_ram_pkg.sv
// Shared types and helpers for the sync_dp_ram block: controller state,
// read-during-write mode encodings and the address-width function.
package sync_dp_ram_pkg;

    // Controller state: CLEAR zeroes the array after reset, READY serves requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Same-address read-during-write behaviour.
    localparam int RDW_OLD = 0;   // read returns the contents before the write
    localparam int RDW_NEW = 1;   // read returns the freshly written lanes

    // Number of address bits needed for 'value' words (at least 1).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sync_dp_ram_rdpipe.sv
// Read output pipeline: RD_LAT stages of valid/data. Valid bits clear on reset,
// so reads in flight when reset hits never surface. Each data stage only loads
// when its incoming valid is set, which makes the last stage hold its value
// between read returns.
module sync_dp_ram_rdpipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    // Chain index 0 is the pipeline input, index RD_LAT the output.
    logic [RD_LAT:0]   w_vld_chain;
    logic [DATA_W-1:0] w_dat_chain [RD_LAT+1];

    assign w_vld_chain[0] = i_valid;
    assign w_dat_chain[0] = i_data;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic              r_vld;
            logic [DATA_W-1:0] r_dat;

            // One pipeline stage: valid always advances, data advances only with valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_dat <= '0;
                end else begin
                    r_vld <= w_vld_chain[gi];
                    if (w_vld_chain[gi]) begin
                        r_dat <= w_dat_chain[gi];
                    end
                end
            end

            assign w_vld_chain[gi+1] = r_vld;
            assign w_dat_chain[gi+1] = r_dat;
        end
    endgenerate

    assign o_valid = w_vld_chain[RD_LAT];
    assign o_data  = w_dat_chain[RD_LAT];

endmodule

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM with byte-lane write enables, selectable read latency
// and read-during-write mode. After reset the array is walked once and zeroed;
// requests are ignored while that clear runs (busy=1).
module sync_dp_ram
    import sync_dp_ram_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 8,
    parameter  int RD_LAT   = 1,
    parameter  int RDW_MODE = RDW_OLD,
    localparam int ADDR_W   = clog2(DEPTH),
    localparam int NBE      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NBE-1:0]    wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    // DEPTH widened by one bit so the range compare also works when DEPTH
    // is an exact power of two.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              w_ready;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_go;
    logic              w_rd_go;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [DATA_W-1:0] w_rd_word;

    assign w_ready       = (r_state == READY);
    assign busy          = ~w_ready;
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign w_wr_go       = w_ready & wr_en & w_wr_in_range;
    // Out-of-range reads still return a (zero) word, so only READY gates them.
    assign w_rd_go       = w_ready & rd_en;
    // Keep the array index inside the declared range; the data is zeroed anyway.
    assign w_rd_idx      = w_rd_in_range ? rd_addr : '0;

    // Clear sequencer: walk 0..DEPTH-1 once after reset, then stay in READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            if (r_clr_cnt == LAST_ADDR) begin
                r_state   <= READY;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // One 8-bit array per byte lane so each lane has its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < NBE; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];
            logic [7:0] w_old;
            logic [7:0] w_new;

            // Lane write port: clear writes zero, READY writes honour the lane enable.
            always_ff @(posedge clk) begin
                if (!w_ready) begin
                    r_lane[r_clr_cnt] <= 8'h00;
                end else if (w_wr_go && wr_be[gi]) begin
                    r_lane[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            assign w_old = w_rd_in_range ? r_lane[w_rd_idx] : 8'h00;

            if (RDW_MODE == RDW_NEW) begin : g_wt
                // Write-through: an enabled lane being written to the same
                // address this edge forwards the new byte.
                assign w_new = (w_wr_go && wr_be[gi] && (wr_addr == rd_addr)) ?
                               wr_data[8*gi +: 8] : w_old;
            end else begin : g_ro
                assign w_new = w_old;
            end

            assign w_rd_word[8*gi +: 8] = w_new;
        end
    endgenerate

    sync_dp_ram_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_rd_go),
        .i_data  (w_rd_word),
        .o_valid (rd_valid),
        .o_data  (rd_data)
    );

endmodule

// File: tb/tb_sync_dp_ram.sv
// Bench for sync_dp_ram: three instances sharing one stimulus stream
//   inst0: 8-bit,  depth 8, latency 1, read-old
//   inst1: 8-bit,  depth 8, latency 2, write-through
//   inst2: 32-bit, depth 6, latency 2, read-old (addresses 6,7 out of range)
// A behavioural model (word arrays plus a delivery schedule) predicts every
// output each cycle.
module tb_sync_dp_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;

    logic [7:0]  a_dat, b_dat;
    logic [31:0] c_dat;
    logic        a_vld, b_vld, c_vld;
    logic        a_busy, b_busy, c_busy;

    logic [2:0]  obs_vld;
    logic [2:0]  obs_busy;
    logic [31:0] obs_dat [3];

    assign obs_vld    = {c_vld, b_vld, a_vld};
    assign obs_busy   = {c_busy, b_busy, a_busy};
    assign obs_dat[0] = {24'h0, a_dat};
    assign obs_dat[1] = {24'h0, b_dat};
    assign obs_dat[2] = c_dat;

    always #5 clk = ~clk;

    sync_dp_ram #(.DATA_W(8), .DEPTH(8), .RD_LAT(1), .RDW_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(a_dat), .rd_valid(a_vld), .busy(a_busy));

    sync_dp_ram #(.DATA_W(8), .DEPTH(8), .RD_LAT(2), .RDW_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(b_dat), .rd_valid(b_vld), .busy(b_busy));

    sync_dp_ram #(.DATA_W(32), .DEPTH(6), .RD_LAT(2), .RDW_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(c_dat), .rd_valid(c_vld), .busy(c_busy));

    // Model configuration per instance
    int dep  [3] = '{8, 8, 6};
    int lat  [3] = '{1, 2, 2};
    int mode [3] = '{0, 1, 0};
    int nbe  [3] = '{1, 1, 4};

    // Model state
    logic [31:0] mem      [3][8];
    int          clr_left [3];
    logic        sched_v  [3][4];
    logic [31:0] sched_d  [3][4];
    logic        exp_vld  [3];
    logic [31:0] exp_dat  [3];
    logic        exp_busy [3];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be, input int nb);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < nb; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            clr_left[k] = dep[k];
            exp_vld[k]  = 1'b0;
            exp_dat[k]  = 32'h0;
            exp_busy[k] = 1'b1;
            for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Advance one clock: model the edge with the inputs currently applied,
    // then return at the following falling edge.
    task automatic tick();
        logic [31:0] rv;
        int slot;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (clr_left[k] > 0) begin
                    clr_left[k]--;
                    if (clr_left[k] == 0)
                        for (int a = 0; a < 8; a++) mem[k][a] = 32'h0;
                end else begin
                    if (rd_en) begin
                        rv = 32'h0;
                        if (int'(rd_addr) < dep[k]) begin
                            rv = mem[k][rd_addr];
                            if (mode[k] == 1 && wr_en && wr_addr == rd_addr)
                                rv = merge(rv, wr_data, wr_be, nbe[k]);
                        end
                        slot = (cyc + lat[k] - 1) % 4;
                        sched_v[k][slot] = 1'b1;
                        sched_d[k][slot] = rv;
                    end
                    if (wr_en && int'(wr_addr) < dep[k])
                        mem[k][wr_addr] = merge(mem[k][wr_addr], wr_data, wr_be, nbe[k]);
                end
                exp_vld[k] = sched_v[k][cyc % 4];
                if (exp_vld[k]) begin
                    exp_dat[k] = sched_d[k][cyc % 4];
                    sched_v[k][cyc % 4] = 1'b0;
                end
                exp_busy[k] = (clr_left[k] > 0);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            if (obs_vld[k]) $display("rd inst%0d cyc%0d data=%h", k, cyc, obs_dat[k]);
    endtask

    task automatic test_reset();
        int done_at [3];
        idle();
        model_reset();
        repeat (3) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL reset_state inst%0d cyc%0d: got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) done_at[k] = -1;
        // Requests while every instance is clearing must be ignored.
        for (int n = 1; n <= 12; n++) begin
            wr_en   = (obs_busy == 3'b111);
            rd_en   = (obs_busy == 3'b111);
            wr_addr = 3'($urandom_range(0, 7));
            rd_addr = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            wr_be   = 4'hF;
            tick();
            for (int k = 0; k < 3; k++) begin
                if (done_at[k] < 0 && obs_busy[k] === 1'b0) done_at[k] = n;
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL clear_seq inst%0d cyc%0d: got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done_at[k] !== dep[k]) begin
                bad++;
                $display("FAIL busy_len inst%0d: got %0d cycles want %0d", k, done_at[k], dep[k]);
            end
        end
        // Every address reads back zero.
        for (int a = 0; a < 10; a++) begin
            rd_en   = (a < 8);
            rd_addr = 3'(a % 8);
            tick();
            for (int k = 0; k < 3; k++) begin
                if (obs_vld[k]) begin
                    total++;
                    if (obs_dat[k] !== 32'h0) begin
                        bad++;
                        $display("FAIL cleared_read inst%0d cyc%0d: got %h want 00000000", k, cyc, obs_dat[k]);
                    end
                end
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k]) begin
                    bad++;
                    $display("FAIL cleared_model inst%0d cyc%0d: got vld=%b dat=%h want vld=%b dat=%h",
                             k, cyc, obs_vld[k], obs_dat[k], exp_vld[k], exp_dat[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_en();
        logic seen;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        rd_en = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) tick();
            if (c_vld) begin
                seen = 1'b1;
                total++;
                if (c_dat !== 32'h00BB00DD) begin
                    bad++;
                    $display("FAIL byte_en cyc%0d: got %h want 00bb00dd", cyc, c_dat);
                end
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k]) begin
                    bad++;
                    $display("FAIL byte_en_model inst%0d cyc%0d: got vld=%b dat=%h want vld=%b dat=%h",
                             k, cyc, obs_vld[k], obs_dat[k], exp_vld[k], exp_dat[k]);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL byte_en_timeout: got no rd_valid want one");
        end
    endtask

    task automatic test_latency();
        int first;
        int nb;
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = 32'h10 + 32'(a); wr_be = 4'hF;
            tick();
        end
        wr_en = 1'b0;
        first = cyc + 1;
        nb = 0;
        for (int n = 0; n < 11; n++) begin
            rd_en   = (n < 8);
            rd_addr = 3'(n % 8);
            tick();
            if (b_vld) begin
                total++;
                if ({24'h0, b_dat} !== 32'h10 + 32'(nb) || cyc !== first + 1 + nb) begin
                    bad++;
                    $display("FAIL latency pulse%0d: got data=%h cyc=%0d want data=%h cyc=%0d",
                             nb, b_dat, cyc, 32'h10 + 32'(nb), first + 1 + nb);
                end
                nb++;
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k]) begin
                    bad++;
                    $display("FAIL latency_model inst%0d cyc%0d: got vld=%b dat=%h want vld=%b dat=%h",
                             k, cyc, obs_vld[k], obs_dat[k], exp_vld[k], exp_dat[k]);
                end
            end
        end
        total++;
        if (nb !== 8) begin
            bad++;
            $display("FAIL latency_count: got %0d pulses want 8", nb);
        end
    endtask

    task automatic test_collision();
        logic [31:0] got [3];
        logic        seen [3];
        logic [31:0] want [3];
        want[0] = 32'h55; want[1] = 32'hA5; want[2] = 32'h55;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55; wr_be = 4'hF;
        tick();
        wr_data = 32'hA5; rd_en = 1'b1; rd_addr = 3'd3;
        for (int k = 0; k < 3; k++) seen[k] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            idle();
            for (int k = 0; k < 3; k++) begin
                if (obs_vld[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    got[k] = obs_dat[k];
                end
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k]) begin
                    bad++;
                    $display("FAIL collision_model inst%0d cyc%0d: got vld=%b dat=%h want vld=%b dat=%h",
                             k, cyc, obs_vld[k], obs_dat[k], exp_vld[k], exp_dat[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (!seen[k] || got[k] !== want[k]) begin
                bad++;
                $display("FAIL collision inst%0d: got seen=%b data=%h want data=%h", k, seen[k], got[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            rd_en   = ($urandom_range(0, 2) != 0);
            wr_addr = 3'($urandom_range(0, 7));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL random inst%0d cyc%0d: got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_inflight();
        int done_at [3];
        rd_en = 1'b1; rd_addr = 3'($urandom_range(0, 5));
        tick();
        idle();
        // Latency-2 reads are now in flight; reset must swallow them.
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_vld[k] !== 1'b0 || obs_dat[k] !== 32'h0 || obs_busy[k] !== 1'b1) begin
                bad++;
                $display("FAIL async_reset inst%0d: got vld=%b dat=%h busy=%b want vld=0 dat=0 busy=1",
                         k, obs_vld[k], obs_dat[k], obs_busy[k]);
            end
        end
        for (int n = 0; n < 6; n++) begin
            if (n == 2) rst_n = 1'b1;
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL inflight inst%0d cyc%0d: got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
        // Four clear cycles done; pulse reset and expect a full restart.
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) done_at[k] = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (done_at[k] < 0 && obs_busy[k] === 1'b0) done_at[k] = n;
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL restart inst%0d cyc%0d: got vld=%b busy=%b want vld=%b busy=%b",
                             k, cyc, obs_vld[k], obs_busy[k], exp_vld[k], exp_busy[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done_at[k] !== dep[k]) begin
                bad++;
                $display("FAIL restart_len inst%0d: got %0d cycles want %0d", k, done_at[k], dep[k]);
            end
        end
        for (int a = 0; a < 10; a++) begin
            rd_en   = (a < 8);
            rd_addr = 3'(a % 8);
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k]) begin
                    bad++;
                    $display("FAIL restart_read inst%0d cyc%0d: got vld=%b dat=%h want vld=%b dat=%h",
                             k, cyc, obs_vld[k], obs_dat[k], exp_vld[k], exp_dat[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_byte_en();
        test_latency();
        test_collision();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
